// File: rtl/steer_en.sv
// Steering enable for a self-balancing platform: detects a rider from two load cells,
// waits for a settled, balanced stance, then allows steering by weight shift.
module steer_en #(
    parameter logic        fast_sim         = 1'b0,
    parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
    parameter logic [11:0] WT_HYSTERESIS    = 12'h040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic [11:0] ld_cell_diff,
    output logic        en_steer,
    output logic        rider_off
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } state_t;

    localparam logic [12:0] THRESH_HI = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, WT_HYSTERESIS};
    localparam logic [12:0] THRESH_LO = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, WT_HYSTERESIS};

    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic [11:0] ld_cell_diff_q, ld_cell_diff_d;
    logic [25:0] tmr_q, tmr_d;
    state_t      state_q, state_d;

    logic [12:0] sum;
    logic [12:0] diff;
    logic [11:0] abs_diff;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;
    logic        tmr_full;

    always_comb begin
        lft_d  = lft_ld;
        rght_d = rght_ld;
    end

    // Arithmetic on the registered samples; |diff| never exceeds 4095 so 12 bits suffice.
    always_comb begin
        sum      = {1'b0, lft_q} + {1'b0, rght_q};
        diff     = {1'b0, lft_q} - {1'b0, rght_q};
        abs_diff = diff[12] ? (rght_q - lft_q) : (lft_q - rght_q);
    end

    always_comb begin
        sum_gt_min    = (sum > THRESH_HI);
        sum_lt_min    = (sum < THRESH_LO);
        diff_gt_1_4   = ({1'b0, abs_diff} > (sum >> 2));
        diff_gt_15_16 = ({1'b0, abs_diff} > (sum - (sum >> 4)));
        tmr_full      = fast_sim ? (&tmr_q[14:0]) : (&tmr_q);
    end

    // Bits 12 and 11 disagreeing means the 13-bit difference is outside 12-bit signed range.
    always_comb begin
        ld_cell_diff_d = diff[11:0];
        if (!diff[12] && diff[11]) begin
            ld_cell_diff_d = 12'h7FF;
        end else if (diff[12] && !diff[11]) begin
            ld_cell_diff_d = 12'h800;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                if (sum_gt_min) begin
                    state_d = WAIT;
                    tmr_d   = '0;
                end
            end
            WAIT: begin
                if (sum_lt_min) begin
                    state_d = IDLE;
                end else if (diff_gt_1_4) begin
                    tmr_d = '0;
                end else if (tmr_full) begin
                    state_d = STEER;
                end else begin
                    tmr_d = tmr_q + 26'd1;
                end
            end
            STEER: begin
                if (sum_lt_min) begin
                    state_d = IDLE;
                end else if (diff_gt_15_16) begin
                    state_d = WAIT;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q          <= '0;
            rght_q         <= '0;
            ld_cell_diff_q <= '0;
            tmr_q          <= '0;
            state_q        <= IDLE;
        end else begin
            lft_q          <= lft_d;
            rght_q         <= rght_d;
            ld_cell_diff_q <= ld_cell_diff_d;
            tmr_q          <= tmr_d;
            state_q        <= state_d;
        end
    end

    always_comb begin
        ld_cell_diff = ld_cell_diff_q;
        en_steer     = (state_q == STEER);
        rider_off    = (state_q == IDLE);
    end

endmodule

// File: tb/tb_steer_en.sv
// Self-checking bench for steer_en (fast_sim=1): scoreboard for ld_cell_diff,
// scenario checks for rider detection, settle timing, steering and reset abort.
module tb_steer_en;

    logic        clk;
    logic        rst_n;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] ld_cell_diff;
    logic        en_steer;
    logic        rider_off;

    typedef struct {
        int          due;
        logic [11:0] exp_diff;
    } ld_exp_t;

    ld_exp_t ld_q[$];
    int      cycle  = 0;
    int      checks = 0;
    int      errors = 0;
    int      cnt;

    steer_en #(
        .fast_sim        (1'b1),
        .MIN_RIDER_WEIGHT(12'h200),
        .WT_HYSTERESIS   (12'h040)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lft_ld      (lft_ld),
        .rght_ld     (rght_ld),
        .ld_cell_diff(ld_cell_diff),
        .en_steer    (en_steer),
        .rider_off   (rider_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [11:0] satDiff(input logic [11:0] l, input logic [11:0] r);
        int d;
        logic [31:0] dv;
        d = int'(l) - int'(r);
        if (d > 2047) return 12'h7FF;
        if (d < -2048) return 12'h800;
        dv = d;
        return dv[11:0];
    endfunction

    // Inputs change at the negedge; the saturated difference is due two rising edges later.
    task automatic applyStimulus(input logic [11:0] l, input logic [11:0] r);
        ld_exp_t e;
        @(negedge clk);
        lft_ld  = l;
        rght_ld = r;
        e.due      = cycle + 2;
        e.exp_diff = satDiff(l, r);
        ld_q.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitForSteer(output int n);
        n = 0;
        while (n < 40000) begin
            @(posedge clk);
            #1;
            n++;
            if (en_steer) break;
        end
    endtask

    always @(posedge clk) begin
        ld_exp_t e;
        #1;
        cycle++;
        while (ld_q.size() > 0 && ld_q[0].due <= cycle) begin
            e = ld_q.pop_front();
            checkOutput("ld_cell_diff", {20'd0, ld_cell_diff}, {20'd0, e.exp_diff});
        end
    end

    initial begin
        rst_n   = 1'b0;
        lft_ld  = 12'hFFF;
        rght_ld = 12'h000;
        waitCycles(2);
        checkOutput("reset_ld_cell_diff", {20'd0, ld_cell_diff}, 32'h0);
        checkOutput("reset_en_steer", {31'd0, en_steer}, 32'd0);
        checkOutput("reset_rider_off", {31'd0, rider_off}, 32'd1);
        @(negedge clk);
        lft_ld  = 12'h000;
        rght_ld = 12'h000;
        rst_n   = 1'b1;
        waitCycles(3);
        checkOutput("idle_rider_off", {31'd0, rider_off}, 32'd1);

        // Rider steps on; abort the settle count at 16000 with an async reset.
        applyStimulus(12'h190, 12'h170);
        waitCycles(1);
        checkOutput("rider_off_after_1", {31'd0, rider_off}, 32'd1);
        waitCycles(1);
        checkOutput("rider_off_after_2", {31'd0, rider_off}, 32'd0);
        waitCycles(16000);
        checkOutput("wait_no_steer", {31'd0, en_steer}, 32'd0);
        checkOutput("wait_ld_diff", {20'd0, ld_cell_diff}, 32'h020);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ld_cell_diff", {20'd0, ld_cell_diff}, 32'h0);
        checkOutput("async_rst_en_steer", {31'd0, en_steer}, 32'd0);
        checkOutput("async_rst_rider_off", {31'd0, rider_off}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        waitForSteer(cnt);
        checkOutput("steer_latency_after_reset", cnt, 32'd32770);

        // In STEER: moderate imbalance and an in-band sum keep steering.
        applyStimulus(12'h200, 12'h100);
        waitCycles(4);
        checkOutput("steer_moderate_diff", {31'd0, en_steer}, 32'd1);
        applyStimulus(12'h0E8, 12'h0E8);
        waitCycles(4);
        checkOutput("steer_band_en", {31'd0, en_steer}, 32'd1);
        checkOutput("steer_band_rider_off", {31'd0, rider_off}, 32'd0);

        // Large imbalance drops back to WAIT.
        applyStimulus(12'h2F0, 12'h010);
        waitCycles(2);
        checkOutput("big_diff_en_steer", {31'd0, en_steer}, 32'd0);
        checkOutput("big_diff_rider_off", {31'd0, rider_off}, 32'd0);

        // Imbalanced stance holds the timer cleared; full count restarts from balance.
        applyStimulus(12'h200, 12'h100);
        waitCycles(2000);
        checkOutput("imbalance_no_steer", {31'd0, en_steer}, 32'd0);
        applyStimulus(12'h180, 12'h180);
        waitForSteer(cnt);
        checkOutput("steer_latency_after_balance", cnt, 32'd32769);

        // Sum below the band: rider off.
        applyStimulus(12'h0D8, 12'h0D8);
        waitCycles(2);
        checkOutput("drop_rider_off", {31'd0, rider_off}, 32'd1);
        checkOutput("drop_en_steer", {31'd0, en_steer}, 32'd0);

        // Threshold boundaries in IDLE and WAIT.
        applyStimulus(12'h0E0, 12'h0E0);
        waitCycles(4);
        checkOutput("idle_sum_1C0", {31'd0, rider_off}, 32'd1);
        applyStimulus(12'h120, 12'h120);
        waitCycles(4);
        checkOutput("idle_sum_240", {31'd0, rider_off}, 32'd1);
        applyStimulus(12'h121, 12'h120);
        waitCycles(2);
        checkOutput("idle_sum_241", {31'd0, rider_off}, 32'd0);
        applyStimulus(12'h0E0, 12'h0E0);
        waitCycles(4);
        checkOutput("wait_sum_1C0_holds", {31'd0, rider_off}, 32'd0);
        applyStimulus(12'h0DF, 12'h0E0);
        waitCycles(2);
        checkOutput("wait_sum_1BF_idle", {31'd0, rider_off}, 32'd1);

        // Saturation corners and random differences.
        applyStimulus(12'hFFF, 12'h000);
        applyStimulus(12'h000, 12'hFFF);
        applyStimulus(12'h100, 12'h140);
        applyStimulus(12'h800, 12'h000);
        applyStimulus(12'h7FF, 12'h000);
        applyStimulus(12'h000, 12'h800);
        applyStimulus(12'h000, 12'h801);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        end
        waitCycles(3);
        checkOutput("scoreboard_drained", ld_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
